ihex_tx_dump: RTL
=================

# ihex_tx_dump

Intel HEX transmitter for the debug probe: on command it reads a range of the 22-bit RAM space and sends it over the UART TX byte interface as Intel HEX text. It is the read-back counterpart of the halt-mode ihex uploader. It sits beside the halt-mode interactor, shares the `o_uart_tx_*` byte port through the interactor's mux, and owns the RAM read port only while the CPU is halted.

## Interface
- REC_LEN, 16: maximum data bytes per type-00 record (1..16).
- RD_LAT, 2: clocks from `rd_o` to valid `rd_data_i` (1..4).
- EOL_CRLF, 1: 1 = each record ends CR LF; 0 = LF only.
- clk24  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- start_i  in  1  one-cycle dump request; sampled only in IDLE.
- base_i  in  22  first RAM address; captured with start_i.
- len_i  in  23  byte count 0..2^22; captured with start_i.
- rd_o  out  1  one-cycle RAM read strobe.
- rd_addr_o  out  22  RAM read address.
- rd_data_i  in  8  RAM read data, valid RD_LAT clocks after rd_o.
- o_uart_tx_data  out  8  ASCII character.
- o_uart_tx_wr  out  1  one-cycle write strobe to the UART TX.
- i_uart_tx_busy  in  1  UART TX busy.
- busy_o  out  1  dump in progress.
- done_o  out  1  one-cycle pulse after the last EOF character is written.

## Operation
- Emitted stream:
  - ELA record (type 04), `:02000004 00XX CC`, where XX = addr[21:16] zero-extended.
  - Data records (type 00) of up to REC_LEN bytes, `:LL AAAA 00 DD.. CC`.
  - EOF record `:00000001FF`.
  - Every record is followed by EOL.
- Hex digits are uppercase ASCII. There are no spaces in the stream.
- Checksum = two's complement of the 8-bit sum of the length, address-high, address-low, type and data bytes (wraps mod 256).
- An ELA record is sent:
  - before the first data record (always);
  - whenever addr[15:0] returns to 0x0000.
- A data record never crosses a 64 KiB boundary. Its length is the minimum of REC_LEN, the remaining count, and the bytes left to the boundary.
- Address arithmetic is 22 bits. 0x3FFFFF+1 wraps to 0x000000 and triggers an ELA record with XX = 00.
- len_i = 0: only the EOF record is sent (no ELA).
- Bytes are read on demand: one rd_o per data byte. The data byte is converted to two characters and added to the running checksum. No record buffer is used.
- State machine: IDLE → ELA → HDR → RD → DATA → (RD | CSUM) → EOL → (ELA | HDR | EOF) → EOF → DONE → IDLE.
  - HDR emits `:`, LL, AAAA and the type.
  - RD waits RD_LAT clocks.
  - DATA emits 2 characters.
  - EOF emits the EOF record plus EOL.
  - DONE lasts 1 cycle and asserts done_o.
- start_i while busy_o = 1 is ignored, and base_i/len_i are not recaptured.

## Timing
- Reset values: rd_o=0, rd_addr_o=0, o_uart_tx_data=0, o_uart_tx_wr=0, busy_o=0, done_o=0. State = IDLE; counters and checksum are cleared.
- rst_n low mid-dump aborts on the next edge. No further characters or reads are issued; a partial record is not completed.
- busy_o rises the cycle after start_i is accepted. It falls in the same cycle done_o pulses.
- Character handshake:
  - o_uart_tx_wr is asserted for exactly one cycle, only when i_uart_tx_busy=0.
  - o_uart_tx_data is stable during that cycle.
  - After each write, busy is ignored for one cycle, because the TX raises busy one cycle late. The next write is no earlier than 2 cycles after the previous one.
- First `:` is written no earlier than 2 cycles after start_i.
- rd_addr_o is valid in the rd_o cycle. rd_data_i is sampled exactly RD_LAT cycles later.
- done_o pulses the cycle after the final EOL character's wr strobe.

## Structure
- Shared package `ihex_pkg`:
  - record-type constants (00, 01, 04);
  - ASCII constants (`:`, CR, LF);
  - function nibble→uppercase hex ASCII;
  - state enum.
  The uploader reuses the type constants from this package.
- One sub-module, `ihex_char_tx`:
  - accepts char + valid and returns ready;
  - implements the wr/busy handshake and the one-cycle blanking after each write.
  The top level holds the record FSM, address/count registers and checksum.

## Test plan
- base=0x000100, len=3, RAM 01 02 03 → `:020000040000FA` `:03010000010203F6` `:00000001FF`, each followed by CR LF; done_o pulses once.
- base=0x00FFF8, len=20 → ELA 0000; 8-byte record at FFF8; `:020000040001F9`; 12-byte record at 0000; EOF.
- base=0x3FFFFF, len=2 → `:02000004003FBB`; 1-byte record at FFFF; `:020000040000FA`; 1-byte record at 0000; EOF.
- len=0 → only `:00000001FF` CR LF; no rd_o; done_o pulses.
- Hold i_uart_tx_busy high for 100 cycles mid-record and randomly elsewhere → no wr while busy; output stream byte-identical to the unstalled run.
- Assert rst_n low mid-data-record, then restart with base=0, len=1 → all outputs 0 after the reset edge; the second dump is complete and correct; start_i during the dump is ignored.

Source files
------------

// File: rtl/ihex_pkg.sv
// Shared Intel HEX definitions: record types, ASCII framing characters,
// hex digit encoding and the dump transmitter state encoding.
package ihex_pkg;

    localparam logic [7:0] REC_DATA    = 8'h00;
    localparam logic [7:0] REC_EOF     = 8'h01;
    localparam logic [7:0] REC_ELA     = 8'h04;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ELA,
        ST_HDR,
        ST_RD,
        ST_DATA,
        ST_CSUM,
        ST_EOL,
        ST_EOF,
        ST_DONE
    } dump_state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Nibble k of a left-aligned byte string, most significant nibble first.
    function automatic logic [3:0] nibble_at(input logic [63:0] bytes, input logic [4:0] k);
        logic [63:0] shifted;
        shifted = bytes << {k, 2'b00};
        return shifted[63:60];
    endfunction

endpackage

// File: rtl/ihex_char_tx.sv
// One-character holding stage in front of the UART TX byte port: writes only
// while the TX is idle and ignores busy for one cycle after each write.
module ihex_char_tx
    import ihex_pkg::*;
(
    input  logic       clk24,
    input  logic       rst_n,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [7:0] o_uart_tx_data,
    output logic       o_uart_tx_wr,
    input  logic       i_uart_tx_busy
);

    logic pend;
    logic blank;

    assign char_ready   = !pend;
    assign o_uart_tx_wr = pend && !blank && !i_uart_tx_busy;

    // The TX raises busy one cycle after a write, so the cycle after a write is blanked.
    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            pend           <= 1'b0;
            blank          <= 1'b0;
            o_uart_tx_data <= 8'h00;
        end else begin
            blank <= o_uart_tx_wr;
            if (char_valid && char_ready) begin
                pend           <= 1'b1;
                o_uart_tx_data <= char_data;
            end else if (o_uart_tx_wr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ihex_tx_dump.sv
// Intel HEX dump of a RAM range over the UART TX byte port; bytes are read on
// demand, one read per data byte, with the checksum accumulated on the fly.
module ihex_tx_dump
    import ihex_pkg::*;
#(
    parameter int REC_LEN  = 16,
    parameter int RD_LAT   = 2,
    parameter int EOL_CRLF = 1
) (
    input  logic        clk24,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [21:0] base_i,
    input  logic [22:0] len_i,
    output logic        rd_o,
    output logic [21:0] rd_addr_o,
    input  logic [7:0]  rd_data_i,
    output logic [7:0]  o_uart_tx_data,
    output logic        o_uart_tx_wr,
    input  logic        i_uart_tx_busy,
    output logic        busy_o,
    output logic        done_o
);

    localparam int         EOL_LEN  = (EOL_CRLF != 0) ? 2 : 1;
    localparam logic [4:0] ELA_LAST = 5'(14 + EOL_LEN);
    localparam logic [4:0] EOF_LAST = 5'(10 + EOL_LEN);
    localparam logic [4:0] EOL_LAST = 5'(EOL_LEN - 1);

    dump_state_t state;
    logic [4:0]  idx;
    logic [21:0] addr;
    logic [22:0] remaining;
    logic [4:0]  rec_left;
    logic [7:0]  data_q;
    logic [7:0]  csum;
    logic [2:0]  lat_cnt;
    logic        draining;

    logic [16:0] to_bound;
    logic [4:0]  rec_len;
    logic [7:0]  ela_cs;
    logic [7:0]  csum_neg;
    logic [63:0] nib_src;
    logic [4:0]  nib_idx;
    logic [4:0]  eol_idx;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic        char_last;
    logic        accept;

    function automatic logic [7:0] eol_char(input logic [4:0] k);
        return (EOL_CRLF != 0 && k == 5'd0) ? ASCII_CR : ASCII_LF;
    endfunction

    // Record length: bounded by REC_LEN, the bytes still to send and the 64 KiB boundary.
    always_comb begin
        to_bound = 17'h10000 - {1'b0, addr[15:0]};
        rec_len  = 5'(REC_LEN);
        if (remaining < {18'h0, rec_len}) rec_len = remaining[4:0];
        if (to_bound < {12'h0, rec_len}) rec_len = to_bound[4:0];
        ela_cs   = ~(8'h06 + {2'b00, addr[21:16]}) + 8'd1;
        csum_neg = ~csum + 8'd1;
    end

    always_comb begin
        char_valid = 1'b0;
        char_last  = 1'b0;
        char_data  = 8'h00;
        nib_src    = 64'h0;
        nib_idx    = idx - 5'd1;
        eol_idx    = 5'd0;
        unique case (state)
            ST_ELA: begin
                char_valid = 1'b1;
                char_last  = (idx == ELA_LAST);
                nib_src    = {8'h02, 8'h00, 8'h00, REC_ELA, 8'h00, 2'b00, addr[21:16], ela_cs, 8'h00};
                eol_idx    = idx - 5'd15;
                if (idx == 5'd0)       char_data = ASCII_COLON;
                else if (idx <= 5'd14) char_data = hex_ascii(nibble_at(nib_src, nib_idx));
                else                   char_data = eol_char(eol_idx);
            end
            ST_HDR: begin
                char_valid = 1'b1;
                char_last  = (idx == 5'd8);
                nib_src    = {3'b000, rec_len, addr[15:8], addr[7:0], REC_DATA, 32'h0};
                if (idx == 5'd0) char_data = ASCII_COLON;
                else             char_data = hex_ascii(nibble_at(nib_src, nib_idx));
            end
            ST_DATA: begin
                char_valid = 1'b1;
                char_last  = (idx == 5'd1);
                nib_src    = {data_q, 56'h0};
                char_data  = hex_ascii(nibble_at(nib_src, idx));
            end
            ST_CSUM: begin
                char_valid = 1'b1;
                char_last  = (idx == 5'd1);
                nib_src    = {csum_neg, 56'h0};
                char_data  = hex_ascii(nibble_at(nib_src, idx));
            end
            ST_EOL: begin
                char_valid = 1'b1;
                char_last  = (idx == EOL_LAST);
                char_data  = eol_char(idx);
            end
            ST_EOF: begin
                char_valid = !draining;
                char_last  = (idx == EOF_LAST);
                nib_src    = {8'h00, 8'h00, 8'h00, REC_EOF, 8'hFF, 24'h0};
                eol_idx    = idx - 5'd11;
                if (idx == 5'd0)       char_data = ASCII_COLON;
                else if (idx <= 5'd10) char_data = hex_ascii(nibble_at(nib_src, nib_idx));
                else                   char_data = eol_char(eol_idx);
            end
            default: begin
                char_valid = 1'b0;
            end
        endcase
    end

    assign accept = char_valid && char_ready;

    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= 5'd0;
            addr      <= 22'h0;
            remaining <= 23'h0;
            rec_left  <= 5'd0;
            data_q    <= 8'h00;
            csum      <= 8'h00;
            lat_cnt   <= 3'd0;
            draining  <= 1'b0;
            rd_o      <= 1'b0;
            rd_addr_o <= 22'h0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            rd_o   <= 1'b0;
            done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        addr      <= base_i;
                        remaining <= len_i;
                        busy_o    <= 1'b1;
                        idx       <= 5'd0;
                        csum      <= 8'h00;
                        draining  <= 1'b0;
                        state     <= (len_i == 23'h0) ? ST_EOF : ST_ELA;
                    end
                end
                ST_ELA: begin
                    if (accept) begin
                        idx <= char_last ? 5'd0 : idx + 5'd1;
                        if (char_last) state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        idx <= char_last ? 5'd0 : idx + 5'd1;
                        if (char_last) begin
                            rec_left  <= rec_len;
                            csum      <= {3'b000, rec_len} + addr[15:8] + addr[7:0];
                            rd_o      <= 1'b1;
                            rd_addr_o <= addr;
                            lat_cnt   <= 3'd0;
                            state     <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (lat_cnt == 3'(RD_LAT)) begin
                        data_q <= rd_data_i;
                        state  <= ST_DATA;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        idx <= char_last ? 5'd0 : idx + 5'd1;
                        if (char_last) begin
                            csum      <= csum + data_q;
                            addr      <= addr + 22'd1;
                            remaining <= remaining - 23'd1;
                            if (rec_left == 5'd1) begin
                                state <= ST_CSUM;
                            end else begin
                                rec_left  <= rec_left - 5'd1;
                                rd_o      <= 1'b1;
                                rd_addr_o <= addr + 22'd1;
                                lat_cnt   <= 3'd0;
                                state     <= ST_RD;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        idx <= char_last ? 5'd0 : idx + 5'd1;
                        if (char_last) state <= ST_EOL;
                    end
                end
                ST_EOL: begin
                    if (accept) begin
                        idx <= char_last ? 5'd0 : idx + 5'd1;
                        if (char_last) begin
                            if (remaining == 23'h0)       state <= ST_EOF;
                            else if (addr[15:0] == 16'h0) state <= ST_ELA;
                            else                          state <= ST_HDR;
                        end
                    end
                end
                ST_EOF: begin
                    // Completion waits until the final character has actually reached the TX.
                    if (draining) begin
                        if (o_uart_tx_wr) begin
                            draining <= 1'b0;
                            done_o   <= 1'b1;
                            busy_o   <= 1'b0;
                            state    <= ST_DONE;
                        end
                    end else if (accept) begin
                        idx <= char_last ? 5'd0 : idx + 5'd1;
                        if (char_last) draining <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ihex_char_tx u_char_tx (
        .clk24          (clk24),
        .rst_n          (rst_n),
        .char_data      (char_data),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .o_uart_tx_data (o_uart_tx_data),
        .o_uart_tx_wr   (o_uart_tx_wr),
        .i_uart_tx_busy (i_uart_tx_busy)
    );

endmodule
